// File: rtl/i2s_rx_if.sv
// i2s_rx_if: codec pins into the I2S receiver and the sample-pair bus it delivers downstream.
// The receiver takes the master modport; the codec/consumer side takes the slave modport.
interface i2s_rx_if #(
  parameter int unsigned DATA_W = 24
) ();

  logic              bclk;
  logic              lrck;
  logic              adcdat;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              frame_err;

  modport master (
    input  bclk,
    input  lrck,
    input  adcdat,
    output out_left,
    output out_right,
    output out_valid,
    output frame_err
  );

  modport slave (
    output bclk,
    output lrck,
    output adcdat,
    input  out_left,
    input  out_right,
    input  out_valid,
    input  frame_err
  );

endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: oversampled I2S deserialiser producing one signed left/right pair per frame.
// Optional short-slot detection is compiled in with I2S_RX_FRAME_CHECK_EN.
module i2s_rx #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = 6
) (
  input  logic     clk,
  input  logic     reset,
  i2s_rx_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [1:0]        bclk_sync;
  logic [1:0]        lrck_sync;
  logic [1:0]        dat_sync;
  logic              bclk_d;
  logic              bclk_rise;
  logic              lrck_s;
  logic              dat_s;
  logic              lrck_prev;
  logic              lrck_edge;
  logic              left_start;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              chan;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic [DATA_W-1:0] slot_word;
  logic              slot_full;
  logic              slot_short;
  logic              slot_done;

  logic [DATA_W-1:0] left_hold;
  logic [DATA_W-1:0] right_hold;
  logic              left_ok;
  logic              pair_go;

  logic [DATA_W-1:0] out_left_q;
  logic [DATA_W-1:0] out_right_q;
  logic              out_valid_q;

  // Two-flop synchronisers plus one extra bclk stage for rise detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      dat_sync  <= 2'b00;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bus.bclk};
      lrck_sync <= {lrck_sync[0], bus.lrck};
      dat_sync  <= {dat_sync[0], bus.adcdat};
      bclk_d    <= bclk_sync[1];
    end
  end

  assign bclk_rise  = bclk_sync[1] & ~bclk_d;
  assign lrck_s     = lrck_sync[1];
  assign dat_s      = dat_sync[1];
  assign lrck_edge  = bclk_rise & (lrck_s ^ lrck_prev);
  assign left_start = lrck_edge & ~lrck_s & (state == IDLE);

  assign sh_next    = {shreg[DATA_W-2:0], dat_s};
  assign slot_short = bclk_rise & (state == SHIFT) & lrck_edge;
  assign slot_full  = bclk_rise & (state == SHIFT) & ~lrck_edge & (cnt == CNT_LAST);

`ifdef I2S_RX_FRAME_CHECK_EN
  assign slot_done = slot_full;
  assign slot_word = sh_next;
`else
  logic [DATA_W-1:0] short_word;

  // A truncated word is left-aligned with the missing LSBs zero-filled
  assign short_word = shreg << (CNT_W'(DATA_W) - cnt);
  assign slot_done  = slot_full | slot_short;
  assign slot_word  = slot_short ? short_word : sh_next;
`endif

  // Slot FSM. The bit sampled on the lrck-edge rise is the I2S delay bit,
  // so every slot enters SHIFT directly from that rise and drops the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      chan      <= 1'b0;
      shreg     <= '0;
      lrck_prev <= 1'b0;
    end else if (bclk_rise) begin
      lrck_prev <= lrck_s;
      unique case (state)
        IDLE: begin
          if (lrck_edge && !lrck_s) begin
            state <= SHIFT;
            cnt   <= '0;
            chan  <= 1'b0;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            cnt  <= '0;
            chan <= lrck_s;
          end else begin
            shreg <= sh_next;
            cnt   <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (lrck_edge) begin
            state <= SHIFT;
            cnt   <= '0;
            chan  <= lrck_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding registers and left/right pairing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_hold  <= '0;
      right_hold <= '0;
      left_ok    <= 1'b0;
      pair_go    <= 1'b0;
    end else begin
      pair_go <= 1'b0;
      if (left_start) begin
        left_ok <= 1'b0;
      end
      if (slot_done) begin
        if (!chan) begin
          left_hold <= slot_word;
          left_ok   <= 1'b1;
        end else begin
          right_hold <= slot_word;
          left_ok    <= 1'b0;
          pair_go    <= left_ok;
        end
      end
`ifdef I2S_RX_FRAME_CHECK_EN
      if (slot_short) begin
        left_ok <= 1'b0;
      end
`endif
    end
  end

  // Published pair; holds between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pair_go;
      if (pair_go) begin
        out_left_q  <= left_hold;
        out_right_q <= right_hold;
      end
    end
  end

  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.out_valid = out_valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= slot_short;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx; a codec model streams I2S frames while a
// monitor pops expected left/right pairs on every out_valid strobe.
module tb_i2s_rx;

  localparam int unsigned DATA_W = 24;

  logic clk;
  logic reset;
  i2s_rx_if #(.DATA_W(DATA_W)) bus ();

  i2s_rx #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          errors = 0;
  int          checks = 0;
  int          ferr_seen = 0;
  int          exp_ferr = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_pair;
  event        lat_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One bclk period: data and word clock change on the falling edge
  task automatic send_bit(input logic l, input logic d, input bit mark);
    bus.bclk   = 1'b0;
    bus.lrck   = l;
    bus.adcdat = d;
    #20;
    bus.bclk = 1'b1;
    if (mark) -> lat_ev;
    #20;
  endtask

  // Slot position 0 is the delay bit, positions 1..nbits carry the word MSB first
  task automatic send_slot(input logic ch, input logic [23:0] word, input int nbits,
                           input int from, input int to, input logic pad, input bit mark);
    logic d;
    for (int i = from; i < to; i++) begin
      d = (i >= 1 && i <= nbits) ? word[24-i] : pad;
      send_bit(ch, d, mark && ch && (i == 24));
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot_len,
                            input logic pad, input bit mark);
    send_slot(1'b0, l, 24, 0, slot_len, pad, 1'b0);
    send_slot(1'b1, r, 24, 0, slot_len, pad, mark);
  endtask

  // out_valid must rise on the 4th clk edge counting the one that first samples bclk high
  task automatic lat_watch();
    @(lat_ev);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 chk("latency_edge3_low", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 chk("latency_edge4_high", 32'(bus.out_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got left=%h right=%h expected no pair at t=%0t",
                 bus.out_left, bus.out_right, $time);
      end else begin
        exp_pair = exp_q.pop_front();
        chk("pair_left", 32'(bus.out_left), 32'(exp_pair[47:24]));
        chk("pair_right", 32'(bus.out_right), 32'(exp_pair[23:0]));
      end
    end
    if (bus.frame_err === 1'b1) begin
      ferr_seen++;
      if (bus.out_valid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL valid_and_frame_err: got both high expected exclusive at t=%0t", $time);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before t=3000000");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ph_opts[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
    int cur_ph;
    int ph;
    int d;
    logic [23:0] l;
    logic [23:0] r;

    reset      = 1'b1;
    bus.bclk   = 1'b1;
    bus.lrck   = 1'b1;
    bus.adcdat = 1'b0;
    #32;
    chk("reset_out_left", 32'(bus.out_left), 32'd0);
    chk("reset_out_right", 32'(bus.out_right), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    #10 reset = 1'b0;
    #20;

    // Full-scale frame with latency measurement
    fork lat_watch(); join_none
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back({24'h7FFFFF, 24'h800000});
    send_frame(24'h7FFFFF, 24'h800000, 32, 1'b1, 1'b1);

    // Back-to-back frames
    exp_q.push_back({24'h000001, 24'hFFFFFF});
    send_frame(24'h000001, 24'hFFFFFF, 32, 1'b0, 1'b0);
    exp_q.push_back({24'h123456, 24'hABCDEF});
    send_frame(24'h123456, 24'hABCDEF, 32, 1'b1, 1'b0);
    exp_q.push_back({24'h000000, 24'h000000});
    send_frame(24'h000000, 24'h000000, 32, 1'b1, 1'b0);

    // Stream resumes mid-right-slot after reset
    reset = 1'b1;
    #20 reset = 1'b0;
    #20;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'(i % 3 == 0), 1'b0);
    exp_q.push_back({24'h5A5A5A, 24'h3C3C3C});
    send_frame(24'h5A5A5A, 24'h3C3C3C, 32, 1'b0, 1'b0);

    // One-cycle reset halfway through a left slot
    send_slot(1'b0, 24'h111111, 24, 0, 12, 1'b0, 1'b0);
    fork
      begin
        #25 reset = 1'b1;
        #1;
        chk("midreset_out_left", 32'(bus.out_left), 32'd0);
        chk("midreset_out_right", 32'(bus.out_right), 32'd0);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        #9 reset = 1'b0;
      end
    join_none
    send_slot(1'b0, 24'h111111, 24, 12, 32, 1'b0, 1'b0);
    send_slot(1'b1, 24'h222222, 24, 0, 32, 1'b0, 1'b0);
    exp_q.push_back({24'h654321, 24'hFEDCBA});
    send_frame(24'h654321, 24'hFEDCBA, 32, 1'b0, 1'b0);

    // Left slot cut to 20 bits
`ifdef I2S_RX_FRAME_CHECK_EN
    exp_ferr++;
`else
    exp_q.push_back({24'hABCDE0, 24'h000010});
`endif
    send_slot(1'b0, 24'hABCDE0, 20, 0, 21, 1'b1, 1'b0);
    send_slot(1'b1, 24'h000010, 24, 0, 32, 1'b1, 1'b0);
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 1'b0, 1'b0);

    // Random frames, slot lengths and bclk/clk phase
    cur_ph = 2;
    for (int f = 0; f < 100; f++) begin
      ph = ph_opts[$urandom_range(0, 7)];
      d = (ph - cur_ph + 10) % 10;
      if (d == 0) d = 10;
      #(d);
      cur_ph = ph;
      l = 24'($urandom);
      r = 24'($urandom);
      exp_q.push_back({l, r});
      send_frame(l, r, $urandom_range(25, 32), 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (20) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_err_count", 32'(ferr_seen), 32'(exp_ferr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
